// File: rtl/rv32i_wb_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave with locked tenures.
// Define RV32I_WB_ARB_TIMEOUT_EN to add the bus-hang watchdog and the RECOVER state.
package rv32i_wb_pkg;
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_master_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;
  } wb_slave_rsp_t;

  function automatic wb_master_req_t wb_master_req_default();
    wb_master_req_t r;
    r = '0;
    return r;
  endfunction
endpackage

module rv32i_wb_arbiter
  import rv32i_wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  wb_master_req_t [NUM_MASTERS-1:0]      m_req_i,
  output wb_slave_rsp_t  [NUM_MASTERS-1:0]      m_rsp_o,
  output wb_master_req_t                        s_req_o,
  input  wb_slave_rsp_t                         s_rsp_i,
  output logic           [NUM_MASTERS-1:0]      grant_o,
  output logic                                  timeout_o
);
  localparam int unsigned IW = $clog2(NUM_MASTERS);
  localparam wb_slave_rsp_t RSP_IDLE = '{rdata: '0, ack: 1'b0, err: 1'b0, stall: 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    BUSY
`ifdef RV32I_WB_ARB_TIMEOUT_EN
    , RECOVER
`endif
  } state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          gidx_q;
  logic [IW-1:0]          last_q;
  logic                   rdy_q;
  logic [IW-1:0]          cand;
  logic [IW-1:0]          sel_idx;
  logic                   found;
  wb_master_req_t         g_req;
  logic                   expire;

  assign g_req = m_req_i[gidx_q];

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = IW'((32'(last_q) + k) % NUM_MASTERS);
      if (!found && m_req_i[cand].cyc) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

`ifdef RV32I_WB_ARB_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        stalled;
  assign stalled = (state_q == BUSY) && g_req.cyc && g_req.stb && !s_rsp_i.ack && !s_rsp_i.err;
  // A response in the expiry cycle wins, since stalled already excludes it.
  assign expire  = stalled && (wdog_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign expire  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      rdy_q   <= 1'b0;
`ifdef RV32I_WB_ARB_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      // rdy_q holds off the first grant until the second edge after reset release.
      rdy_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rdy_q && found) begin
            state_q <= BUSY;
            gidx_q  <= sel_idx;
            grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << sel_idx;
          end
        end
        BUSY: begin
          if (!g_req.cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
          end
`ifdef RV32I_WB_ARB_TIMEOUT_EN
          else if (expire) begin
            state_q <= RECOVER;
          end
`endif
        end
`ifdef RV32I_WB_ARB_TIMEOUT_EN
        RECOVER: begin
          if (!g_req.cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
`ifdef RV32I_WB_ARB_TIMEOUT_EN
      if ((state_q != BUSY) || !g_req.cyc || expire || s_rsp_i.ack || s_rsp_i.err) begin
        wdog_q <= '0;
      end else if (g_req.stb) begin
        wdog_q <= wdog_q + 16'd1;
      end
`endif
    end
  end

  always_comb begin
    s_req_o = wb_master_req_default();
    m_rsp_o = {NUM_MASTERS{RSP_IDLE}};
    if (state_q == BUSY) begin
      if (g_req.cyc) begin
        s_req_o = g_req;
      end
      m_rsp_o[gidx_q] = s_rsp_i;
      if (expire) begin
        m_rsp_o[gidx_q].err = 1'b1;
      end
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = expire;
endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Vector-table bench for rv32i_wb_arbiter with two masters and an 8-cycle watchdog.
module tb_rv32i_wb_arbiter;
  import rv32i_wb_pkg::*;

  localparam logic [31:0] ADR0  = 32'h1000_0000;
  localparam logic [31:0] RDATA = 32'hCAFE_0000;

  typedef struct packed {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic       err;
    logic [1:0] grant;
    logic       scyc;
    logic [1:0] mack;
    logic [1:0] merr;
    logic [1:0] mstall;
    logic       tmo;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  wb_master_req_t [1:0]     m_req;
  wb_slave_rsp_t  [1:0]     m_rsp;
  wb_master_req_t           s_req;
  wb_slave_rsp_t            s_rsp;
  logic [1:0]               grant;
  logic                     tmo;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t exp_q[$];
  vec_t tbl[23];

  rv32i_wb_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_rsp_o(m_rsp),
    .s_req_o(s_req), .s_rsp_i(s_rsp), .grant_o(grant), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] cyc, logic [1:0] stb, logic ack, logic err,
                              logic [1:0] gnt, logic scyc, logic [1:0] mack,
                              logic [1:0] merr, logic [1:0] mstall, logic t);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.grant = gnt; v.scyc = scyc;
    v.mack = mack; v.merr = merr; v.mstall = mstall; v.tmo = t;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive at the current negedge, check mid low phase, then advance to the next negedge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    for (int i = 0; i < 2; i++) begin
      m_req[i].cyc = v.cyc[i];
      m_req[i].stb = v.stb[i];
    end
    s_rsp.ack = v.ack;
    s_rsp.err = v.err;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    chk({tag, " grant"}, 64'(grant), 64'(e.grant));
    chk({tag, " s_cyc"}, 64'(s_req.cyc), 64'(e.scyc));
    if (e.scyc) chk({tag, " s_adr"}, 64'(s_req.adr), 64'(ADR0 + (e.grant[1] ? 32'd1 : 32'd0)));
    chk({tag, " m_ack"}, 64'({m_rsp[1].ack, m_rsp[0].ack}), 64'(e.mack));
    chk({tag, " m_err"}, 64'({m_rsp[1].err, m_rsp[0].err}), 64'(e.merr));
    chk({tag, " m_stall"}, 64'({m_rsp[1].stall, m_rsp[0].stall}), 64'(e.mstall));
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s m%0d_rdata", tag, i), 64'(m_rsp[i].rdata), 64'(e.mstall[i] ? 32'd0 : RDATA));
    chk({tag, " timeout"}, 64'(tmo), 64'(e.tmo));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_req[i]     = wb_master_req_default();
      m_req[i].we  = 1'b1;
      m_req[i].adr = ADR0 + 32'(i);
      m_req[i].dat = 32'h5500_0000 + 32'(i);
      m_req[i].sel = 4'hF;
    end
    s_rsp       = '0;
    s_rsp.rdata = RDATA;

    tbl[0]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tbl[1]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tbl[2]  = mk(2'b11, 2'b11, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b10, 0);
    tbl[3]  = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 2'b01, 2'b00, 2'b10, 0);
    tbl[4]  = mk(2'b10, 2'b10, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b10, 0);
    tbl[5]  = mk(2'b10, 2'b10, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tbl[6]  = mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b00, 2'b01, 0);
    for (int i = 7; i <= 10; i++)
      tbl[i] = mk(2'b11, 2'b11, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 0);
    tbl[11] = mk(2'b01, 2'b01, 1, 0, 2'b10, 0, 2'b10, 2'b00, 2'b01, 0);
    tbl[12] = mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tbl[13] = mk(2'b01, 2'b01, 1, 0, 2'b01, 1, 2'b01, 2'b00, 2'b10, 0);
    tbl[14] = mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b10, 0);
    tbl[15] = mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tbl[16] = mk(2'b01, 2'b01, 0, 1, 2'b01, 1, 2'b00, 2'b01, 2'b10, 0);
    tbl[17] = mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b10, 0);
    tbl[18] = mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tbl[19] = mk(2'b01, 2'b01, 1, 0, 2'b01, 1, 2'b01, 2'b00, 2'b10, 0);
    tbl[20] = mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b10, 0);
    tbl[21] = mk(2'b00, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tbl[22] = mk(2'b00, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);

    // Reset state with the clock running.
    repeat (3) @(negedge clk);
    #2;
    chk("rst grant", 64'(grant), 64'd0);
    chk("rst s_cyc", 64'(s_req.cyc), 64'd0);
    chk("rst timeout", 64'(tmo), 64'd0);
    chk("rst m_stall", 64'({m_rsp[1].stall, m_rsp[0].stall}), 64'd3);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) apply($sformatf("v%0d", i), tbl[i]);

    // Watchdog: m1 granted, slave never answers.
    apply("wd0", mk(2'b10, 2'b10, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0));
    for (int k = 1; k <= 9; k++) begin
`ifdef RV32I_WB_ARB_TIMEOUT_EN
      if (k < 8)       apply($sformatf("wd%0d", k), mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b00, 2'b01, 0));
      else if (k == 8) apply("wd8", mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b10, 2'b01, 1));
      else             apply("wd9", mk(2'b10, 2'b10, 0, 0, 2'b10, 0, 2'b00, 2'b00, 2'b11, 0));
`else
      apply($sformatf("wd%0d", k), mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b00, 2'b01, 0));
`endif
    end
`ifdef RV32I_WB_ARB_TIMEOUT_EN
    apply("wd10", mk(2'b00, 2'b00, 0, 0, 2'b10, 0, 2'b00, 2'b00, 2'b11, 0));
`else
    apply("wd10", mk(2'b00, 2'b00, 0, 0, 2'b10, 0, 2'b00, 2'b00, 2'b01, 0));
`endif
    apply("wd11", mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0));

    // Ack arriving on what would be the expiry cycle must win; sole requester regranted.
    apply("ak0", mk(2'b10, 2'b10, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0));
    for (int k = 1; k <= 7; k++)
      apply($sformatf("ak%0d", k), mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b00, 2'b01, 0));
    apply("ak8", mk(2'b10, 2'b10, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 0));
    apply("ak9", mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 2'b00, 2'b00, 2'b01, 0));

    // Asynchronous reset in the middle of m1's burst, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst grant", 64'(grant), 64'd0);
    chk("arst s_cyc", 64'(s_req.cyc), 64'd0);
    chk("arst timeout", 64'(tmo), 64'd0);
    chk("arst m_stall", 64'({m_rsp[1].stall, m_rsp[0].stall}), 64'd3);
    @(negedge clk);
    rst_n = 1'b1;
    apply("rs0", mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0));
    apply("rs1", mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0));
    apply("rs2", mk(2'b11, 2'b11, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b10, 0));
    apply("rs3", mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b10, 0));
    apply("rs4", mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/rv32i_wb_arbiter.md
RV32I_WB_ARBITER -- requirements
Module: rv32i_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone requesters (range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, bus-hang watchdog limit in cycles (range 1..65535).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port m_req_i  input  NUM_MASTERS x wb_master_req_t (rv32i_wb_pkg)  per-master request.
REQ-006 SHALL have port m_rsp_o  output  NUM_MASTERS x wb_slave_rsp_t  per-master response.
REQ-007 SHALL have port s_req_o  output  wb_master_req_t  request to the shared slave.
REQ-008 SHALL have port s_rsp_i  input  wb_slave_rsp_t  response from the shared slave.
REQ-009 SHALL have port grant_o  output  NUM_MASTERS  one-hot current grant, all-zero when none.
REQ-010 SHALL have port timeout_o  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RECOVER; RECOVER reachable only with the watchdog compiled in.
REQ-012 IDLE: if any m_req_i[i].cyc=1, SHALL select the first requester at or after (last_grant+1) mod NUM_MASTERS, register it into grant_o, and enter BUSY next cycle; arbitration latency 1 cycle.
REQ-013 IDLE with no cyc asserted SHALL remain IDLE with grant_o=0.
REQ-014 BUSY: s_req_o SHALL equal m_req_i[granted] combinationally; m_rsp_o[granted] SHALL equal s_rsp_i combinationally.
REQ-015 Non-granted masters SHALL see rdata=0, ack=0, err=0, stall=1 in every state.
REQ-016 When not BUSY, s_req_o SHALL be wb_master_req_default() (cyc=0, stb=0).
REQ-017 Grant SHALL be held while granted master keeps cyc=1 (locked multi-beat tenure); requests from others SHALL NOT preempt.
REQ-018 Granted master's cyc=0 in BUSY SHALL drive s_req_o.cyc=0 that cycle, update last_grant to the granted index, and return to IDLE next cycle (one idle cycle between tenures).
REQ-019 cyc drop in the same cycle as s_rsp_i.ack SHALL pass the ack to the master and release as REQ-018.
REQ-020 Round-robin pointer SHALL wrap from NUM_MASTERS-1 to 0; a sole requester SHALL be regranted repeatedly.
REQ-021 Requests with stb=1 while cyc=0 SHALL be ignored.

Reset
REQ-022 rst_ni=0 SHALL immediately force IDLE, grant_o=0, timeout_o=0, last_grant=NUM_MASTERS-1 (master 0 wins first), watchdog count=0, s_req_o defaulted, regardless of in-flight transfer.
REQ-023 After rst_ni deassertion, first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-024 Macro RV32I_WB_ARB_TIMEOUT_EN SHALL compile in the watchdog; without it, no counter, no RECOVER state, timeout_o tied 0.
REQ-025 With macro: 16-bit counter SHALL increment each BUSY cycle with granted cyc=1 and stb=1 and s_rsp_i.ack=0 and s_rsp_i.err=0, and clear on ack, err, or leaving BUSY.
REQ-026 With macro: when count reaches TIMEOUT_CYCLES, SHALL drive err=1 to the granted master for exactly one cycle, pulse timeout_o, drop s_req_o.cyc, enter RECOVER.
REQ-027 RECOVER SHALL keep s_req_o defaulted and granted master stalled, then go IDLE once its cyc=0, updating last_grant.
REQ-028 ack or err arriving in the expiry cycle SHALL take priority; no timeout asserted, counter cleared.

Verification
REQ-029 Reset, m0 and m1 assert cyc+stb in same cycle -> grant_o=01 after 1 cycle; after m0 releases, grant_o=10 two cycles after m0 cyc drop.
REQ-030 m1 holds cyc for 4 acked beats while m0 requests -> grant_o stays 10, m0 sees stall=1, ack=0 throughout.
REQ-031 Only m0 requests three back-to-back tenures -> regranted each time, one idle cycle between.
REQ-032 With RV32I_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> err and timeout_o pulse together on the 8th stalled cycle, s_req_o.cyc=0 next, IDLE after master drops cyc.
REQ-033 rst_ni pulsed low mid-burst -> s_req_o.cyc=0 and grant_o=0 with no clock edge; next grant goes to m0.
